// File: rtl/shifter_seq_if.sv
// Handshake bundle between the core and the multi-cycle shifter.
// The core uses the master side and the shifter uses the slave side.
interface shifter_seq_if #(
  parameter int WIDTH = 32
);
  localparam int SA_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       SRO;
  logic [SA_W-1:0]  SA;
  logic [WIDTH-1:0] Data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             busy;

  modport master (
    output in_valid, SRO, SA, Data, out_ready,
    input  in_ready, out_valid, Result, busy
  );

  modport slave (
    input  in_valid, SRO, SA, Data, out_ready,
    output in_ready, out_valid, Result, busy
  );
endinterface

// File: rtl/shifter_seq.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter that applies at most STEP bits per clock.
// Operands and results move over valid/ready handshakes.
module shifter_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic          clk,
  input  logic          rst,
  shifter_seq_if.slave  bus
);
  localparam int SA_W = $clog2(WIDTH);
  localparam logic [SA_W:0] STEP_L = (SA_W + 1)'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;
  logic [SA_W-1:0]  r_rem;
  logic [SA_W-1:0]  w_rem_next;
  logic [1:0]       r_op;
  logic [1:0]       w_op_next;
  logic [SA_W-1:0]  w_k;
  logic [WIDTH-1:0] r_result;

  // Applies one partial shift of k bits. ROR takes the low half of a doubled word.
  function automatic logic [WIDTH-1:0] step_shift(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [SA_W-1:0]  k
  );
    logic [2*WIDTH-1:0] dbl;
    dbl = {a, a} >> k;
    case (op)
      2'd0:    step_shift = a << k;
      2'd1:    step_shift = a >> k;
      2'd2:    step_shift = $signed(a) >>> k;
      2'd3:    step_shift = dbl[WIDTH-1:0];
      default: step_shift = a;
    endcase
  endfunction

  // Chunk size for this cycle: k = min(rem, STEP).
  always_comb begin
    w_k = r_rem;
    if ({1'b0, r_rem} > STEP_L) begin
      w_k = STEP_L[SA_W-1:0];
    end else begin
      w_k = r_rem;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_rem_next   = r_rem;
    w_op_next    = r_op;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_acc_next   = bus.Data;
          w_rem_next   = bus.SA;
          w_op_next    = bus.SRO;
          w_state_next = (bus.SA == {SA_W{1'b0}}) ? S_DONE : S_SHIFT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_acc_next = step_shift(r_op, r_acc, w_k);
        w_rem_next = r_rem - w_k;
        if (r_rem == w_k) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_SHIFT;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= {WIDTH{1'b0}};
      r_rem   <= {SA_W{1'b0}};
      r_op    <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_rem   <= w_rem_next;
      r_op    <= w_op_next;
    end
  end

  // Result is captured only on entry to DONE, so it holds through IDLE/SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= {WIDTH{1'b0}};
    end else if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
      r_result <= w_acc_next;
    end else begin
      r_result <= r_result;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign bus.Result    = r_result;
endmodule

// File: tb/tb_shifter_seq.sv
// Directed and random checks of shifter_seq against a bit-level reference model.
module tb_shifter_seq;
  localparam int WIDTH = 32;
  localparam int STEP  = 8;
  localparam int SA_W  = $clog2(WIDTH);

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [WIDTH-1:0] last_res;

  shifter_seq_if #(.WIDTH(WIDTH)) bus ();

  shifter_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Each result bit picked straight from its source bit position.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op, input logic [WIDTH-1:0] d, input int sa);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (op)
        2'd0:    r[i] = (i >= sa) ? d[i - sa] : 1'b0;
        2'd1:    r[i] = (i + sa < WIDTH) ? d[i + sa] : 1'b0;
        2'd2:    r[i] = (i + sa < WIDTH) ? d[i + sa] : d[WIDTH-1];
        default: r[i] = d[(i + sa) % WIDTH];
      endcase
    end
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input int sa,
                        input logic [WIDTH-1:0] data, input int gap, input bit keep_valid);
    int n;
    int cyc;
    logic [WIDTH-1:0] exp;
    exp = ref_shift(op, data, sa);
    n   = (sa + STEP - 1) / STEP;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.SRO      = op;
    bus.SA       = SA_W'(sa);
    bus.Data     = data;
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      bus.in_valid = 1'b0;
      bus.SRO      = 2'($urandom);
      bus.SA       = SA_W'($urandom);
      bus.Data     = $urandom;
    end
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      chk({tag, " busy_shift"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, " result_hold"}, bus.Result, last_res);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, n);
    chk({tag, " result"}, bus.Result, exp);
    chk({tag, " in_ready_done"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, " busy_done"}, {31'd0, bus.busy}, 32'd1);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      chk({tag, " stall_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, " stall_result"}, bus.Result, exp);
      chk({tag, " stall_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, " idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, " idle_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, " idle_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " idle_result"}, bus.Result, exp);
    last_res = exp;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.SRO       = 2'd0;
    bus.SA        = '0;
    bus.Data      = '0;
    bus.out_ready = 1'b0;
    last_res      = '0;
    #12;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_result", bus.Result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("sll31", 2'd0, 31, 32'h0000_0001, 0, 1'b0);
    run_op("sra4", 2'd2, 4, 32'h8000_0000, 1, 1'b0);
    run_op("ror12", 2'd3, 12, 32'h1234_5678, 0, 1'b0);
    run_op("srl0", 2'd1, 0, 32'hDEAD_BEEF, 3, 1'b1);
    run_op("stall5", 2'd1, 9, 32'hF0F0_1234, 5, 1'b0);

    // Abandon an operation mid-shift.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.SRO      = 2'd0;
    bus.SA       = SA_W'(31);
    bus.Data     = 32'h0000_0001;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_result", bus.Result, 32'd0);
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 2'd0, 1, 32'h0000_0003, 0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      run_op("rand", 2'($urandom), int'($urandom_range(WIDTH - 1, 0)), $urandom,
             int'($urandom_range(3, 0)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
